// File: rtl/mycpu_pkg.sv
// Shared types and constants for the mycpu divide unit.
package mycpu_pkg;

  localparam int DIV_WIDTH = 32;

  // Bit replicated across the quotient on divide-by-zero (all ones).
  localparam logic DIV_ZERO_FILL = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/mycpu_div_step.sv
// One radix-2 restoring iteration: shift {rem,quot} left, trial-subtract divisor.
module mycpu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quot,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_nx,
  output logic [WIDTH-1:0] quot_nx
);

  logic [WIDTH:0]   sh;
  logic [WIDTH-1:0] diff;
  logic             ge;

  assign sh   = {rem, quot[WIDTH-1]};
  assign ge   = sh >= {1'b0, divisor};
  // rem < divisor on entry, so a successful subtraction always fits in WIDTH bits.
  assign diff = sh[WIDTH-1:0] - divisor;

  assign rem_nx  = ge ? diff : sh[WIDTH-1:0];
  assign quot_nx = {quot[WIDTH-2:0], ge};

endmodule

// File: rtl/mycpu_div_unit.sv
// Iterative 32-bit DIV/DIVU unit for the EX stage; quotient to LO, remainder to HI.
module mycpu_div_unit
  import mycpu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_signed,
  input  logic [WIDTH-1:0] req_dividend,
  input  logic [WIDTH-1:0] req_divisor,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_quot,
  output logic [WIDTH-1:0] resp_rem,
  output logic             resp_divzero
);

  div_state_e       state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_q, quot_q, dvsr_q, rem_nx, quot_nx;
  logic             neg_q, neg_r;
  logic             accept, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == DONE);
  assign accept     = req_valid && req_ready && !flush;

  // Magnitudes are plain unsigned: -(0x80000000) wraps back to 0x80000000.
  assign a_neg = req_signed & req_dividend[WIDTH-1];
  assign b_neg = req_signed & req_divisor[WIDTH-1];
  assign a_mag = a_neg ? -req_dividend : req_dividend;
  assign b_mag = b_neg ? -req_divisor  : req_divisor;

  mycpu_div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem_q),
    .quot    (quot_q),
    .divisor (dvsr_q),
    .rem_nx  (rem_nx),
    .quot_nx (quot_nx)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = (req_divisor == '0) ? DONE : BUSY;
      BUSY: if (flush) state_nx = IDLE;
            else if (cnt == CNT_W'(WIDTH-1)) state_nx = FIX;
      FIX:  state_nx = flush ? IDLE : DONE;
      DONE: if (flush || resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      rem_q        <= '0;
      quot_q       <= '0;
      dvsr_q       <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      resp_quot    <= '0;
      resp_rem     <= '0;
      resp_divzero <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (accept) begin
          cnt    <= '0;
          rem_q  <= '0;
          quot_q <= a_mag;
          dvsr_q <= b_mag;
          neg_q  <= a_neg ^ b_neg;
          neg_r  <= a_neg;
          // Divide-by-zero skips the datapath and answers straight from DONE.
          if (req_divisor == '0) begin
            resp_quot    <= {WIDTH{DIV_ZERO_FILL}};
            resp_rem     <= req_dividend;
            resp_divzero <= 1'b1;
          end
        end
        BUSY: begin
          rem_q  <= rem_nx;
          quot_q <= quot_nx;
          cnt    <= cnt + CNT_W'(1);
        end
        FIX: begin
          resp_quot    <= neg_q ? -quot_q : quot_q;
          resp_rem     <= neg_r ? -rem_q  : rem_q;
          resp_divzero <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mycpu_div_unit.sv
// Scoreboard bench for mycpu_div_unit: driver pushes model results, monitor pops on response.
module tb_mycpu_div_unit;

  typedef struct packed {
    logic [31:0] quot;
    logic [31:0] rem;
    logic        dz;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_signed = 1'b0;
  logic [31:0] req_dividend = '0;
  logic [31:0] req_divisor = '0;
  logic        flush = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_quot;
  logic [31:0] resp_rem;
  logic        resp_divzero;

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  mycpu_div_unit dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_signed   (req_signed),
    .req_dividend (req_dividend),
    .req_divisor  (req_divisor),
    .flush        (flush),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_quot    (resp_quot),
    .resp_rem     (resp_rem),
    .resp_divzero (resp_divzero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: truncating division on 64-bit integers; divide-by-zero is a fixed answer.
  function automatic exp_t model(input bit s, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa, sb;
    if (b == 0) begin
      e.quot = 32'hFFFF_FFFF; e.rem = a; e.dz = 1'b1;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      e.quot = 32'(sa / sb); e.rem = 32'(sa % sb); e.dz = 1'b0;
    end else begin
      e.quot = a / b; e.rem = a % b; e.dz = 1'b0;
    end
    return e;
  endfunction

  // Monitor: compare the head of the scoreboard every cycle a response is shown.
  always @(negedge clk) begin
    #2;
    if (!reset && !flush && resp_valid) begin
      if (exp_q.size() == 0) begin
        chk("stale_resp_valid", 32'(resp_valid), 32'd0);
      end else begin
        chk("quot", resp_quot, exp_q[0].quot);
        chk("rem", resp_rem, exp_q[0].rem);
        chk("divzero", 32'(resp_divzero), 32'(exp_q[0].dz));
        if (resp_ready) void'(exp_q.pop_front());
      end
    end
  end

  // abort: 0 = run to completion, 1 = flush at BUSY cycle 10, 2 = reset at BUSY cycle 10.
  task automatic run_op(input bit s, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input int abort);
    int lat;
    int exp_lat;
    bit busy_ok;
    @(negedge clk);
    chk("idle_req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_signed = s; req_dividend = a; req_divisor = b;
    resp_ready = (hold == 0);
    exp_q.push_back(model(s, a, b));
    exp_lat = (b == 0) ? 1 : 34;
    @(negedge clk);
    req_valid = 1'b0;
    req_dividend = $urandom; req_divisor = $urandom;
    lat = 1;
    if (abort != 0) begin
      repeat (9) @(negedge clk);
      if (abort == 1) flush = 1'b1; else reset = 1'b1;
      @(negedge clk);
      flush = 1'b0; reset = 1'b0;
      void'(exp_q.pop_back());
      chk("abort_resp_valid", 32'(resp_valid), 32'd0);
      chk("abort_req_ready", 32'(req_ready), 32'd1);
      if (abort == 2) begin
        chk("reset_quot", resp_quot, 32'd0);
        chk("reset_rem", resp_rem, 32'd0);
        chk("reset_divzero", 32'(resp_divzero), 32'd0);
      end
      resp_ready = 1'b1;
      return;
    end
    busy_ok = 1'b1;
    while (!resp_valid && lat < 100) begin
      if (req_ready) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("busy_req_ready_low", 32'(busy_ok && !req_ready), 32'd1);
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      resp_ready = 1'b1;
    end
    @(negedge clk);
    chk("resp_valid_drop", 32'(resp_valid), 32'd0);
    chk("req_ready_back", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_quot", resp_quot, 32'd0);
    chk("rst_rem", resp_rem, 32'd0);
    chk("rst_divzero", 32'(resp_divzero), 32'd0);
    reset = 1'b0;

    run_op(1'b0, 32'd100, 32'd7, 0, 0);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 0);
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 0, 0);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 0, 0);
    run_op(1'b0, 32'h1234_5678, 32'd0, 0, 0);
    run_op(1'b1, 32'h8765_4321, 32'd0, 2, 0);
    run_op(1'b0, 32'hDEAD_BEEF, 32'd13, 5, 0);

    // Flush in IDLE with a request pending must not accept it.
    @(negedge clk);
    req_valid = 1'b1; req_divisor = 32'd5; flush = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    chk("idle_flush_no_accept", 32'(req_ready), 32'd1);

    run_op(1'b0, 32'hFFFF_0000, 32'd3, 0, 1);
    run_op(1'b0, 32'd9, 32'd3, 0, 0);
    run_op(1'b1, 32'h8000_0001, 32'd7, 0, 2);
    run_op(1'b0, 32'd9, 32'd3, 0, 0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom_range(0, 15);
        1: b = -32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      run_op(1'($urandom_range(0, 1)), a, b, $urandom_range(0, 3), 0);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
